// File: rtl/issue_arbiter_pkg.sv
// Shared unit IDs and default latencies for the issue arbiter, the issue
// queues and the CDB source mux.
package issue_arbiter_pkg;

  typedef logic [1:0] unit_t;
  localparam int LAT_W = 4;
  typedef logic [LAT_W-1:0] lat_t;

  localparam unit_t UNIT_INT = 2'd0;
  localparam unit_t UNIT_MEM = 2'd1;
  localparam unit_t UNIT_MUL = 2'd2;
  localparam unit_t UNIT_DIV = 2'd3;

  localparam int DEFAULT_MUL_LAT = 4;
  localparam int DEFAULT_DIV_LAT = 8;

endpackage

// File: rtl/issue_arbiter_if.sv
// Issue-queue handshake and CDB source-select bundle between the arbiter
// (master) and the queues / CDB mux (slave).
interface issue_arbiter_if;
  import issue_arbiter_pkg::*;

  logic  equeueint_ready;
  logic  equeueint_done;
  logic  equeuemem_ready;
  logic  equeuemem_done;
  logic  equeuemul_ready;
  logic  equeuemul_done;
  logic  equeuediv_ready;
  logic  equeuediv_done;
  logic  div_busy;
  unit_t cdb_src;
  logic  cdb_src_valid;

  modport master (
    input  equeueint_ready, equeuemem_ready, equeuemul_ready, equeuediv_ready,
    output equeueint_done, equeuemem_done, equeuemul_done, equeuediv_done,
    output div_busy, cdb_src, cdb_src_valid
  );

  modport slave (
    output equeueint_ready, equeuemem_ready, equeuemul_ready, equeuediv_ready,
    input  equeueint_done, equeuemem_done, equeuemul_done, equeuediv_done,
    input  div_busy, cdb_src, cdb_src_valid
  );

endinterface

// File: rtl/issue_arbiter_slot.sv
// CDB reservation ring: slot[k] set means the bus is taken k cycles from now,
// with the reserving unit held alongside.
module cdb_slot_ring
  import issue_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DIV_LAT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           grant_vld,
  input  lat_t           grant_lat,
  input  unit_t          grant_owner,
  output logic [DEPTH:0] slot,
  output unit_t          owner0
);

  logic [DEPTH:0] slot_q;
  unit_t          owner_q [DEPTH:0];

  // A grant of latency L lands in slot L-1 after this edge's shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      for (int k = 0; k <= DEPTH; k++) owner_q[k] <= UNIT_INT;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (grant_vld && (grant_lat == lat_t'(k + 1))) begin
          slot_q[k]  <= 1'b1;
          owner_q[k] <= grant_owner;
        end else begin
          slot_q[k]  <= slot_q[k+1];
          owner_q[k] <= owner_q[k+1];
        end
      end
      slot_q[DEPTH]  <= 1'b0;
      owner_q[DEPTH] <= UNIT_INT;
    end
  end

  assign slot   = slot_q;
  assign owner0 = owner_q[0];

endmodule

// File: rtl/issue_arbiter.sv
// Issue-stage scheduler: one grant per cycle across INT/MEM/MUL/DIV queues,
// reserving the CDB cycle in which the granted unit's result will appear.
module issue_arbiter
  import issue_arbiter_pkg::*;
#(
  parameter int MUL_LAT = DEFAULT_MUL_LAT,
  parameter int DIV_LAT = DEFAULT_DIV_LAT
) (
  input  logic clk,
  input  logic reset,
  issue_arbiter_if.master q
);

  logic [DIV_LAT:0] slot;
  unit_t            owner0;
  logic [3:0]       div_cnt;
  logic             lru;
  logic             div_busy_int;
  logic             elig_int, elig_mem, elig_mul, elig_div;
  logic             grant_vld;
  lat_t             grant_lat;
  unit_t            grant_owner;
  logic             unused_slot_bits;

  assign div_busy_int = (div_cnt != 4'd0);

  // Eligibility looks at the pre-shift ring, so slot[L] is the target cycle.
  assign elig_int = q.equeueint_ready & ~slot[1];
  assign elig_mem = q.equeuemem_ready & ~slot[1];
  assign elig_mul = q.equeuemul_ready & ~slot[MUL_LAT];
  assign elig_div = q.equeuediv_ready & ~slot[DIV_LAT] & ~div_busy_int;

  always_comb begin
    grant_vld   = 1'b0;
    grant_lat   = '0;
    grant_owner = UNIT_INT;
    if (!reset) begin
      if (elig_div) begin
        grant_vld   = 1'b1;
        grant_lat   = lat_t'(DIV_LAT);
        grant_owner = UNIT_DIV;
      end else if (elig_mul) begin
        grant_vld   = 1'b1;
        grant_lat   = lat_t'(MUL_LAT);
        grant_owner = UNIT_MUL;
      end else if (elig_int && (!elig_mem || !lru)) begin
        grant_vld   = 1'b1;
        grant_lat   = lat_t'(1);
        grant_owner = UNIT_INT;
      end else if (elig_mem) begin
        grant_vld   = 1'b1;
        grant_lat   = lat_t'(1);
        grant_owner = UNIT_MEM;
      end
    end
  end

  assign q.equeueint_done = grant_vld && (grant_owner == UNIT_INT);
  assign q.equeuemem_done = grant_vld && (grant_owner == UNIT_MEM);
  assign q.equeuemul_done = grant_vld && (grant_owner == UNIT_MUL);
  assign q.equeuediv_done = grant_vld && (grant_owner == UNIT_DIV);

  // lru: 0 prefers INT, 1 prefers MEM; div_cnt counts the divider's remaining busy cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= 4'd0;
      lru     <= 1'b0;
    end else begin
      if (grant_vld && (grant_owner == UNIT_DIV)) div_cnt <= 4'(DIV_LAT - 1);
      else if (div_busy_int)                      div_cnt <= div_cnt - 4'd1;
      if (grant_vld && (grant_owner == UNIT_INT))      lru <= 1'b1;
      else if (grant_vld && (grant_owner == UNIT_MEM)) lru <= 1'b0;
    end
  end

  cdb_slot_ring #(.DEPTH(DIV_LAT)) u_ring (
    .clk         (clk),
    .rst         (reset),
    .grant_vld   (grant_vld),
    .grant_lat   (grant_lat),
    .grant_owner (grant_owner),
    .slot        (slot),
    .owner0      (owner0)
  );

  // Intermediate ring positions only feed the shift chain.
  assign unused_slot_bits = ^slot;

  assign q.div_busy      = div_busy_int & ~reset;
  assign q.cdb_src_valid = slot[0] & ~reset;
  assign q.cdb_src       = reset ? UNIT_INT : owner0;

endmodule

// File: tb/tb_issue_arbiter.sv
// Directed bench for issue_arbiter: per-cycle grant checks plus a CDB
// scoreboard of expected (cycle, source) reservations.
module tb_issue_arbiter;
  import issue_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  issue_arbiter_if bus();

  issue_arbiter #(.MUL_LAT(4), .DIV_LAT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  typedef struct {
    int    cyc;
    unit_t src;
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  t       = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic push(input int c, input unit_t s);
    ev_t e;
    e.cyc = c;
    e.src = s;
    sb.push_back(e);
  endtask

  // rdy / exp_done bit order: {div, mul, mem, int}
  task automatic cycle(input logic rst_i, input logic [3:0] rdy,
                       input logic [3:0] exp_done, input logic exp_busy);
    int    idx;
    unit_t exp_src;
    reset               = rst_i;
    bus.equeueint_ready = rdy[0];
    bus.equeuemem_ready = rdy[1];
    bus.equeuemul_ready = rdy[2];
    bus.equeuediv_ready = rdy[3];
    @(negedge clk);
    chk("done", {28'd0, bus.equeuediv_done, bus.equeuemul_done,
                 bus.equeuemem_done, bus.equeueint_done}, {28'd0, exp_done});
    chk("div_busy", {31'd0, bus.div_busy}, {31'd0, exp_busy});
    idx     = -1;
    exp_src = UNIT_INT;
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].cyc == t) idx = i;
    if (idx >= 0) begin
      exp_src = sb[idx].src;
      sb.delete(idx);
    end
    chk("cdb_src_valid", {31'd0, bus.cdb_src_valid}, (idx >= 0) ? 32'd1 : 32'd0);
    if (idx >= 0 || rst_i) chk("cdb_src", {30'd0, bus.cdb_src}, {30'd0, exp_src});
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    sb.delete();
    t = -1;
    cycle(1'b1, 4'b1111, 4'b0000, 1'b0);
  endtask

  initial begin
    bus.equeueint_ready = 1'b0;
    bus.equeuemem_ready = 1'b0;
    bus.equeuemul_ready = 1'b0;
    bus.equeuediv_ready = 1'b0;

    // INT streaming
    do_reset();
    while (t < 6) begin
      push(t + 1, UNIT_INT);
      cycle(1'b0, 4'b0001, 4'b0001, 1'b0);
    end
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);

    // INT/MEM alternation starting with INT
    do_reset();
    while (t < 6) begin
      push(t + 1, (t % 2 == 1) ? UNIT_MEM : UNIT_INT);
      cycle(1'b0, 4'b0011, (t % 2 == 1) ? 4'b0010 : 4'b0001, 1'b0);
    end
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);

    // MUL reservation blocks a later INT for one cycle
    do_reset();
    push(4, UNIT_MUL);
    cycle(1'b0, 4'b0100, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0001, 4'b0000, 1'b0);
    push(5, UNIT_INT);
    cycle(1'b0, 4'b0001, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);

    // DIV continuously ready: grants every DIV_LAT cycles
    do_reset();
    while (t < 26) begin
      if (t % 8 == 0 && t <= 16) push(t + 8, UNIT_DIV);
      cycle(1'b0, (t <= 16) ? 4'b1000 : 4'b0000,
            (t % 8 == 0 && t <= 16) ? 4'b1000 : 4'b0000,
            (t % 8 != 0) && (t < 24));
    end

    // All four ready together: priority order and CDB interleave
    do_reset();
    push(8, UNIT_DIV);
    cycle(1'b0, 4'b1111, 4'b1000, 1'b0);
    push(5, UNIT_MUL);
    cycle(1'b0, 4'b0111, 4'b0100, 1'b1);
    push(3, UNIT_INT);
    cycle(1'b0, 4'b0011, 4'b0001, 1'b1);
    push(4, UNIT_MEM);
    cycle(1'b0, 4'b0010, 4'b0010, 1'b1);
    while (t < 10) cycle(1'b0, 4'b0000, 4'b0000, (t < 8));

    // Mid-operation reset discards reservations and restores INT preference
    do_reset();
    cycle(1'b0, 4'b0100, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0001, 4'b0001, 1'b0);
    cycle(1'b1, 4'b1111, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    push(5, UNIT_INT);
    cycle(1'b0, 4'b0011, 4'b0001, 1'b0);
    push(6, UNIT_MEM);
    cycle(1'b0, 4'b0010, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 4'b0000, 1'b0);

    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_arbiter.md
# issue_arbiter

Issue-stage scheduler for the Tomasulo back end. It sits between four execution issue queues (integer, load/store, multiply, divide) and the shared common data bus (CDB), and grants at most one issue per cycle. Each grant reserves the CDB slot in which that unit's result will appear, so results never collide on the bus. The reservation is also used to drive the CDB source select.

## Interface
Parameters:
- MUL_LAT, 4, multiplier latency in cycles (pipelined, 2..DIV_LAT-1)
- DIV_LAT, 8, divider latency in cycles (non-pipelined, ≤15)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- equeueint_ready  in  1  integer queue has an issuable entry (latency 1)
- equeueint_done  out  1  grant to integer queue this cycle
- equeuemem_ready  in  1  load/store queue has an issuable entry (latency 1)
- equeuemem_done  out  1  grant to load/store queue
- equeuemul_ready  in  1  multiply queue ready (latency MUL_LAT)
- equeuemul_done  out  1  grant to multiply queue
- equeuediv_ready  in  1  divide queue ready (latency DIV_LAT)
- equeuediv_done  out  1  grant to divide queue
- div_busy  out  1  divider occupied
- cdb_src  out  2  unit owning CDB this cycle: 0 INT, 1 MEM, 2 MUL, 3 DIV
- cdb_src_valid  out  1  a reserved result is on the CDB this cycle

## Operation
- State: slot[0..DIV_LAT] (1 bit each), owner[0..DIV_LAT] (2 bits each), div_cnt (4 bits), lru (1 bit: 0 means INT preferred).
- slot[k]=1 means the CDB is reserved k cycles from now. owner[k] holds the reserving unit.
- A candidate with latency L is eligible iff ready=1, slot[L]=0, and (for DIV) div_busy=0.
- Grant goes to the highest-priority eligible candidate, in the order DIV > MUL > {INT, MEM}.
- When both INT and MEM are eligible, the winner is selected by lru. A lower-priority candidate wins when a higher one is ineligible.
- The done outputs are combinational from the current ready inputs and state. At most one done is high per cycle.
- Slot shift on each edge:
  - slot[k] ← slot[k+1] | (grant with L == k+1)
  - owner shifts in the same way.
  - slot[DIV_LAT+1] is taken as 0.
- cdb_src_valid = slot[0]; cdb_src = owner[0].
- lru update:
  - toggles to MEM-preferred after an INT grant
  - toggles to INT-preferred after a MEM grant
  - unchanged otherwise
- Divider busy:
  - a DIV grant loads div_cnt ← DIV_LAT-1; otherwise div_cnt decrements while non-zero.
  - div_busy = (div_cnt ≠ 0).
- A continuous MUL stream can starve INT/MEM. This is accepted behaviour; dispatch throttling is outside this block.

## Timing
- Reset values: all slot=0, owner=0, div_cnt=0, lru=0.
- All done outputs, cdb_src_valid and div_busy are forced 0 while reset=1. cdb_src=0.
- A reset asserted mid-operation discards all pending reservations. Results in flight are the execution units' concern.
- Grant at cycle t:
  - INT/MEM result on CDB at t+1
  - MUL result at t+MUL_LAT
  - DIV result at t+DIV_LAT
  - cdb_src_valid is high exactly in that cycle.
- After a DIV grant at t, the next DIV grant is possible at t+DIV_LAT at the earliest.
- Queues deassert or advance ready on the edge where done=1. The arbiter holds no memory of a request that was not granted.
- Simultaneous events: a grant's reservation and the slot shift occur on the same edge. The slot[L] check uses the pre-shift state.

## Structure
- Shared package: unit-ID constants (UNIT_INT/MEM/MUL/DIV) and default MUL_LAT/DIV_LAT. The equeue* and CDB mux consume the same IDs.
- One sub-module: cdb_slot_ring.
  - Holds the parameterised slot/owner shift register.
  - Inputs: grant valid, latency, owner.
  - Outputs: slot vector, owner[0].
- Priority/LRU selection and div_cnt stay in issue_arbiter.

## Test plan
Defaults apply: MUL_LAT=4, DIV_LAT=8.

1. INT ready continuously from cycle 0 after reset → equeueint_done=1 every cycle; cdb_src_valid=1 from cycle 1 with cdb_src=0.
2. INT and MEM both ready continuously → done alternates INT, MEM, INT…, starting with INT; cdb_src alternates 0, 1 one cycle later.
3. MUL ready only at cycle 0, INT ready only at cycle 3 → MUL granted at 0; INT blocked at 3 (slot 1 taken) and granted at 4 if ready is held; CDB shows MUL (2) at 4 and INT (0) at 5.
4. DIV ready continuously → grants at cycles 0, 8, 16; div_busy=1 during cycles 1–7; cdb_src=3 with valid at 8 and 16.
5. All four ready at cycle 0 → DIV at 0, MUL at 1, INT at 2, MEM at 3; CDB valid at cycles 3, 4, 5, 8 with sources 0, 1, 2, 3 respectively.
6. MUL granted at 0, then reset asserted at cycle 2 → cdb_src_valid stays 0 at cycle 4; div_busy=0; INT preferred first after reset deasserts.
